// File: rtl/maxpool2x2_sequencer.sv
// 2x2 / stride-2 max-pool sequencer over a sync-read feature-map RAM.
// Pixels are sign-magnitude bytes; 8'h80 is a dominant marker that always wins the pool.

module max_in_4 (
  input  logic [31:0] window,
  output logic [7:0]  max_val
);

  // Pairwise winner under the sign-magnitude ordering; the marker beats everything.
  function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h80) return a;
    if (b == 8'h80) return b;
    if (a[7] != b[7]) return a[7] ? b : a;
    if (!a[7]) return (a[6:0] >= b[6:0]) ? a : b;
    return (a[6:0] <= b[6:0]) ? a : b;
  endfunction

  logic [7:0] lo_max;
  logic [7:0] hi_max;

  always_comb begin
    lo_max  = pick(window[7:0], window[15:8]);
    hi_max  = pick(window[23:16], window[31:24]);
    max_val = pick(lo_max, hi_max);
  end

endmodule

module maxpool2x2_sequencer #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int ADDR_W     = 10,
  parameter int OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    EMIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] orow;
  logic [ADDR_W-1:0] ocol;
  logic [1:0]        idx;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [7:0]        win [4];
  logic [31:0]       window;
  logic              last_win;
  logic              last_col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  assign last_col = (ocol == ADDR_W'(OUT_W - 1));
  assign last_win = last_col && (orow == ADDR_W'(OUT_H - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    wr_valid   = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (idx == 2'd3) state_next = CAPT;
      end
      CAPT: begin
        busy       = 1'b1;
        state_next = EMIT;
      end
      EMIT: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        if (wr_ready) state_next = last_win ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window walk: idx steps through the 2x2 quad, ocol/orow advance on each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orow    <= '0;
      ocol    <= '0;
      idx     <= '0;
      wr_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            orow    <= '0;
            ocol    <= '0;
            idx     <= '0;
            wr_addr <= '0;
          end
        end
        FETCH: idx <= idx + 2'd1;
        EMIT: begin
          if (wr_ready && !last_win) begin
            wr_addr <= wr_addr + OUT_ADDR_W'(1);
            if (last_col) begin
              ocol <= '0;
              orow <= orow + ADDR_W'(1);
            end else begin
              ocol <= ocol + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    row     = (orow << 1) + ADDR_W'(idx[1]);
    col     = (ocol << 1) + ADDR_W'(idx[0]);
    rd_addr = (state == FETCH) ? (row * ADDR_W'(IMG_W) + col) : '0;
  end

  // RAM data arrives one cycle after the strobe, so the strobe and its index
  // are delayed by one stage; rd_data is ignored whenever cap_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en  <= 1'b0;
      cap_idx <= '0;
    end else begin
      cap_en  <= (state == FETCH);
      cap_idx <= idx;
    end
  end

  // NOTE: the window is four flops, not a RAM macro, so it is reset; this makes
  // wr_data read 8'h00 out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) win[i] <= '0;
    end else if (cap_en) begin
      win[cap_idx] <= rd_data;
    end
  end

  assign window = {win[3], win[2], win[1], win[0]};

  max_in_4 u_max (
    .window  (window),
    .max_val (wr_data)
  );

endmodule

// File: tb/tb_maxpool2x2_sequencer.sv
// Bench for maxpool2x2_sequencer: a 4x4 instance for ordering, timing, backpressure and reset,
// plus a 5x3 instance for odd dimensions. Expected bytes come from a signed-ordering model.
`timescale 1ns/1ps
module tb_maxpool2x2_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_start, a_busy, a_done, a_rd_en, a_wr_valid, a_wr_ready;
  logic [3:0] a_rd_addr;
  logic [7:0] a_rd_data, a_wr_data;
  logic [1:0] a_wr_addr;

  logic       b_start, b_busy, b_done, b_rd_en, b_wr_valid, b_wr_ready;
  logic [3:0] b_rd_addr;
  logic [7:0] b_rd_data, b_wr_data;
  logic [0:0] b_wr_addr;

  maxpool2x2_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .OUT_ADDR_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );

  maxpool2x2_sequencer #(.IMG_W(5), .IMG_H(3), .ADDR_W(4), .OUT_ADDR_W(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  // Sync-read RAMs; garbage is presented whenever no read was issued.
  always @(posedge clk) a_rd_data <= a_rd_en ? mem_a[a_rd_addr] : 8'($urandom);
  always @(posedge clk) b_rd_data <= b_rd_en ? mem_b[b_rd_addr] : 8'($urandom);

  int checks = 0;
  int errors = 0;

  int         wr_cyc_q [$];
  int         wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         rd_q [$];
  int         done_cyc;
  int         done_cnt;

  // Sign-magnitude value mapped to an ordinary integer; the marker ranks above all.
  function automatic int rank(input logic [7:0] v);
    if (v == 8'h80) return 1000;
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  function automatic logic [7:0] pool4(input logic [7:0] p0, p1, p2, p3);
    logic [7:0] best;
    best = p0;
    if (rank(p1) > rank(best)) best = p1;
    if (rank(p2) > rank(best)) best = p2;
    if (rank(p3) > rank(best)) best = p3;
    return best;
  endfunction

  function automatic logic [7:0] model_a(input int k);
    int r0, c0;
    r0 = 2 * (k / 2);
    c0 = 2 * (k % 2);
    return pool4(mem_a[r0*4+c0], mem_a[r0*4+c0+1], mem_a[(r0+1)*4+c0], mem_a[(r0+1)*4+c0+1]);
  endfunction

  function automatic int rd_order_a(input int n);
    int k, i;
    k = n / 4;
    i = n % 4;
    return (2 * (k / 2) + i / 2) * 4 + 2 * (k % 2) + i % 2;
  endfunction

  // Runs one pass on the 4x4 instance from an idle negedge; optionally holds
  // wr_ready low for stall_len cycles when output stall_idx is offered.
  task automatic run_pass_a(input int stall_idx, input int stall_len);
    int         stall_left;
    bit         stalled;
    logic [1:0] hold_a;
    logic [7:0] hold_d;
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete();
    done_cyc = -1; done_cnt = 0; stall_left = stall_len; stalled = 0;
    hold_a = '0; hold_d = '0;
    a_wr_ready = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start got %b want 1", a_busy);
    end
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      if (a_rd_en) rd_q.push_back(int'(a_rd_addr));
      if (a_done) begin done_cyc = cyc; done_cnt++; end
      a_wr_ready = 1'b1;
      if (a_wr_valid) begin
        if (stalled) begin
          checks++;
          if (a_wr_addr !== hold_a || a_wr_data !== hold_d || a_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc %0d got addr %0d data %h rd_en %b want addr %0d data %h rd_en 0",
                     cyc, a_wr_addr, a_wr_data, a_rd_en, hold_a, hold_d);
          end
        end
        if (stall_left > 0 && int'(a_wr_addr) == stall_idx) begin
          stalled = 1; hold_a = a_wr_addr; hold_d = a_wr_data;
          a_wr_ready = 1'b0; stall_left--;
        end else begin
          stalled = 0;
          wr_cyc_q.push_back(cyc); wr_addr_q.push_back(int'(a_wr_addr)); wr_data_q.push_back(a_wr_data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done_cyc < 0) begin
      errors++; $display("FAIL done_timeout got no done want done within 400 cycles");
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a_busy, a_done, a_rd_en, a_wr_valid, a_rd_addr, a_wr_addr, a_wr_data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_a got busy %b done %b rd_en %b wr_valid %b rd_addr %0d wr_addr %0d wr_data %h want all 0",
               a_busy, a_done, a_rd_en, a_wr_valid, a_rd_addr, a_wr_addr, a_wr_data);
    end
    checks++;
    if ({b_busy, b_done, b_rd_en, b_wr_valid, b_rd_addr, b_wr_addr, b_wr_data} !== 18'd0) begin
      errors++;
      $display("FAIL reset_b got busy %b done %b rd_en %b wr_valid %b rd_addr %0d wr_addr %0d wr_data %h want all 0",
               b_busy, b_done, b_rd_en, b_wr_valid, b_rd_addr, b_wr_addr, b_wr_data);
    end
  endtask

  task automatic test_ramp(input string tag, input int stall_idx, input int stall_len);
    logic [7:0] want [4];
    int         want_cyc;
    want[0] = 8'h05; want[1] = 8'h07; want[2] = 8'h0D; want[3] = 8'h0F;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    run_pass_a(stall_idx, stall_len);
    checks++;
    if (wr_data_q.size() != 4) begin
      errors++; $display("FAIL %s_write_count got %0d want 4", tag, wr_data_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        want_cyc = 5 + 6 * k + ((stall_idx >= 0 && k >= stall_idx) ? stall_len : 0);
        checks++;
        if (wr_addr_q[k] != k || wr_data_q[k] !== want[k] || wr_cyc_q[k] != want_cyc) begin
          errors++;
          $display("FAIL %s_write%0d got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d",
                   tag, k, wr_addr_q[k], wr_data_q[k], wr_cyc_q[k], k, want[k], want_cyc);
        end
      end
      checks++;
      if (done_cyc != wr_cyc_q[3] + 1 || done_cnt != 1) begin
        errors++;
        $display("FAIL %s_done_timing got cyc %0d count %0d want cyc %0d count 1", tag, done_cyc, done_cnt, wr_cyc_q[3] + 1);
      end
    end
    checks++;
    if (rd_q.size() != 16) begin
      errors++; $display("FAIL %s_read_count got %0d want 16", tag, rd_q.size());
    end else begin
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (rd_q[n] != rd_order_a(n)) begin
          errors++; $display("FAIL %s_read%0d got addr %0d want %0d", tag, n, rd_q[n], rd_order_a(n));
        end
      end
    end
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL %s_after_done got done %b busy %b want 0 0", tag, a_done, a_busy);
    end
  endtask

  task automatic test_signs_and_marker();
    logic [7:0] want [4];
    logic [7:0] init [16];
    init = '{8'h05, 8'h83, 8'h85, 8'h82,
             8'h02, 8'h84, 8'h87, 8'h81,
             8'h7F, 8'h80, 8'h00, 8'h00,
             8'h01, 8'h00, 8'h00, 8'h00};
    want[0] = 8'h05; want[1] = 8'h81; want[2] = 8'h80; want[3] = 8'h00;
    mem_a = init;
    run_pass_a(-1, 0);
    checks++;
    if (wr_data_q.size() != 4) begin
      errors++; $display("FAIL signs_write_count got %0d want 4", wr_data_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_data_q[k] !== want[k]) begin
          errors++; $display("FAIL signs_window%0d got %h want %h", k, wr_data_q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midpass();
    bit found;
    bit leak;
    found = 0;
    leak  = 0;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    a_wr_ready = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      if (a_rd_en && a_rd_addr == 4'd8) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midpass_reach got no fetch of addr 8 want fetch of output 2");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_rd_en, a_wr_valid, a_rd_addr, a_wr_addr, a_wr_data} !== 19'd0) begin
      errors++;
      $display("FAIL midpass_reset got busy %b done %b rd_en %b wr_valid %b rd_addr %0d wr_addr %0d wr_data %h want all 0",
               a_busy, a_done, a_rd_en, a_wr_valid, a_rd_addr, a_wr_addr, a_wr_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_done || a_rd_en || a_wr_valid || a_busy) leak = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_done || a_rd_en || a_wr_valid || a_busy) leak = 1;
    end
    checks++;
    if (leak) begin
      errors++; $display("FAIL midpass_quiet got activity after reset want none until start");
    end
    test_ramp("restart", -1, 0);
  endtask

  task automatic test_random();
    int stall_idx, stall_len;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) mem_a[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      stall_idx = $urandom_range(0, 3);
      stall_len = $urandom_range(0, 5);
      run_pass_a(stall_idx, stall_len);
      checks++;
      if (wr_data_q.size() != 4) begin
        errors++; $display("FAIL random%0d_write_count got %0d want 4", it, wr_data_q.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (wr_addr_q[k] != k || wr_data_q[k] !== model_a(k)) begin
            errors++;
            $display("FAIL random%0d_write%0d got addr %0d data %h want addr %0d data %h",
                     it, k, wr_addr_q[k], wr_data_q[k], k, model_a(k));
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_odd_dims();
    int         want_rd [8];
    bit         idle_bad;
    logic [7:0] want_d;
    want_rd = '{0, 1, 5, 6, 2, 3, 7, 8};
    idle_bad = 0;
    for (int i = 0; i < 16; i++) mem_b[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
    wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete();
    done_cyc = -1; done_cnt = 0;
    b_wr_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (b_rd_en) rd_q.push_back(int'(b_rd_addr));
      if (b_wr_valid && b_wr_ready) begin
        wr_addr_q.push_back(int'(b_wr_addr)); wr_data_q.push_back(b_wr_data);
      end
      if (b_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc && (b_busy || b_wr_valid || b_rd_en)) idle_bad = 1;
      if (done_cyc >= 0 && cyc >= done_cyc + 20) break;
      b_start = (cyc == 2) || (b_done === 1'b1);
      @(negedge clk);
    end
    b_start = 1'b0;
    checks++;
    if (done_cnt != 1 || idle_bad) begin
      errors++; $display("FAIL odd_single_done got done count %0d restarted %0d want 1 0", done_cnt, idle_bad);
    end
    checks++;
    if (wr_data_q.size() != 2) begin
      errors++; $display("FAIL odd_write_count got %0d want 2", wr_data_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        want_d = pool4(mem_b[2*k], mem_b[2*k+1], mem_b[5+2*k], mem_b[6+2*k]);
        checks++;
        if (wr_addr_q[k] != k || wr_data_q[k] !== want_d) begin
          errors++;
          $display("FAIL odd_write%0d got addr %0d data %h want addr %0d data %h", k, wr_addr_q[k], wr_data_q[k], k, want_d);
        end
      end
    end
    checks++;
    if (rd_q.size() != 8) begin
      errors++; $display("FAIL odd_read_count got %0d want 8", rd_q.size());
    end else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (rd_q[n] != want_rd[n]) begin
          errors++; $display("FAIL odd_read%0d got addr %0d want %0d", n, rd_q[n], want_rd[n]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_wr_ready = 1'b1; b_wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_ramp("ramp", -1, 0);
    @(negedge clk);
    test_signs_and_marker();
    @(negedge clk);
    test_ramp("backpressure", 1, 10);
    @(negedge clk);
    test_reset_midpass();
    @(negedge clk);
    test_random();
    test_odd_dims();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
